amba3ahblite_master_widget: RTL and testbench

AHB-Lite initiator (bus master) that turns a simple valid/ready register-access request stream into AMBA3 AHB-Lite single transfers. It is the master-side counterpart to the AHB-Lite register-file slave widget, used by test harnesses and by on-chip sequencers that program generated register blocks. It supports one transfer in the address phase overlapped with one in the data phase. It handles wait states and the two-cycle ERROR response by cancelling and re-issuing the pipelined transfer.

---
 rtl/amba3ahblite_master_widget.sv | 121 ++++++++++++
 tb/tb_amba3ahblite_master_widget.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/amba3ahblite_master_widget.sv
// AHB-Lite single-transfer initiator: valid/ready register requests in, pipelined
// address/data phases out, with the two-cycle ERROR response cancelling the queued transfer.
module amba3ahblite_master_widget #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [1:0]  HTRANS,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic        a_vld_reg;
    logic [31:0] a_addr_reg;
    logic        a_write_reg;
    logic [2:0]  a_size_reg;
    logic [31:0] a_wdata_reg;
    logic        d_vld_reg;
    logic        d_write_reg;
    logic [31:0] d_wdata_reg;
    logic        cancel_reg;
    logic        rsp_vld_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;

    logic accept;
    logic promote;
    logic complete;

    // Holding req_rdy low during reset keeps a requester from handshaking into a cleared slot.
    assign req_rdy  = HRESETn && !cancel_reg && (!a_vld_reg || HREADY);
    assign accept   = req_vld && req_rdy;
    assign promote  = HREADY && a_vld_reg && !cancel_reg;
    assign complete = d_vld_reg && HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_vld_reg   <= 1'b0;
            a_addr_reg  <= 32'h0;
            a_write_reg <= 1'b0;
            a_size_reg  <= 3'b000;
            a_wdata_reg <= 32'h0;
        end else if (accept) begin
            // An accept with A occupied implies A is being promoted on this same edge.
            a_vld_reg   <= 1'b1;
            a_addr_reg  <= req_addr;
            a_write_reg <= req_write;
            a_size_reg  <= req_size;
            a_wdata_reg <= req_wdata;
        end else if (promote) begin
            a_vld_reg   <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_vld_reg   <= 1'b0;
            d_write_reg <= 1'b0;
            d_wdata_reg <= 32'h0;
        end else if (promote) begin
            d_vld_reg   <= 1'b1;
            d_write_reg <= a_write_reg;
            d_wdata_reg <= a_wdata_reg;
        end else if (complete) begin
            d_vld_reg   <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cancel_reg <= 1'b0;
        end else if (d_vld_reg && HRESP && !HREADY) begin
            cancel_reg <= 1'b1;
        end else if (HREADY) begin
            cancel_reg <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_vld_reg   <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'h0;
        end else begin
            rsp_vld_reg   <= complete;
            rsp_err_reg   <= complete && HRESP;
            rsp_rdata_reg <= (complete && !d_write_reg) ? HRDATA : 32'h0;
        end
    end

    assign HTRANS    = (a_vld_reg && !cancel_reg) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr_reg;
    assign HWRITE    = a_write_reg;
    assign HSIZE     = a_size_reg;
    assign HWDATA    = d_wdata_reg;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign rsp_vld   = rsp_vld_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
endmodule

// File: tb/tb_amba3ahblite_master_widget.sv
// Directed bench for the AHB-Lite initiator: writes, pipelined reads, wait states,
// two-cycle ERROR with re-issue, byte access and reset during a data phase.
module tb_amba3ahblite_master_widget;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_vld;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    int checks   = 0;
    int failures = 0;

    amba3ahblite_master_widget #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        req_vld   = 1'b1;
        req_addr  = a;
        req_write = w;
        req_size  = s;
        req_wdata = d;
    endtask

    initial begin
        HRESETn = 1'b0;
        req_vld = 1'b0; req_addr = '0; req_write = 1'b0; req_size = 3'd0; req_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        #2;
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_vld", {31'h0, rsp_vld}, 32'h0);
        chk("rst_req_rdy", {31'h0, req_rdy}, 32'h0);
        step(); step();
        HRESETn = 1'b1;
        #1;
        $display("reset released");

        // 1: single word write
        issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        #1 chk("t1_req_rdy", {31'h0, req_rdy}, 32'h1);
        step(); req_vld = 1'b0;
        chk("t1_htrans", {30'h0, HTRANS}, 32'h2);
        chk("t1_haddr", HADDR, 32'h10);
        chk("t1_hwrite", {31'h0, HWRITE}, 32'h1);
        chk("t1_hsize", {29'h0, HSIZE}, 32'h2);
        step();
        chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
        chk("t1_htrans_idle", {30'h0, HTRANS}, 32'h0);
        step();
        chk("t1_rsp_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t1_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        $display("txn write 0x10 rsp_vld=%0d rsp_err=%0d", rsp_vld, rsp_err);
        step();
        chk("t1_rsp_done", {31'h0, rsp_vld}, 32'h0);

        // 2: back-to-back reads
        issue(32'h0, 1'b0, 3'd2, 32'h0);
        step();
        issue(32'h4, 1'b0, 3'd2, 32'h0);
        HRDATA = 32'h11;
        step(); req_vld = 1'b0;
        chk("t2_haddr_pipe", HADDR, 32'h4);
        chk("t2_htrans_pipe", {30'h0, HTRANS}, 32'h2);
        step();
        HRDATA = 32'h22;
        chk("t2_rsp0_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t2_rsp0_rdata", rsp_rdata, 32'h11);
        $display("txn read 0x0 rdata=0x%08h", rsp_rdata);
        step();
        chk("t2_rsp1_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t2_rsp1_rdata", rsp_rdata, 32'h22);
        $display("txn read 0x4 rdata=0x%08h", rsp_rdata);
        step();
        chk("t2_rsp_done", {31'h0, rsp_vld}, 32'h0);

        // 3: three wait states on a read with a second read queued
        issue(32'h30, 1'b0, 3'd2, 32'hA5A5A5A5);
        step();
        issue(32'h34, 1'b0, 3'd2, 32'h0);
        step();
        issue(32'h38, 1'b0, 3'd2, 32'h0);
        HREADY = 1'b0; HRDATA = 32'h33;
        #1 chk("t3_req_rdy_stall", {31'h0, req_rdy}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_haddr_hold", HADDR, 32'h34);
            chk("t3_htrans_hold", {30'h0, HTRANS}, 32'h2);
            chk("t3_hwdata_hold", HWDATA, 32'hA5A5A5A5);
            chk("t3_no_rsp", {31'h0, rsp_vld}, 32'h0);
            chk("t3_req_rdy", {31'h0, req_rdy}, 32'h0);
        end
        HREADY = 1'b1; req_vld = 1'b0;
        step();
        HRDATA = 32'h44;
        chk("t3_rsp0_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t3_rsp0_rdata", rsp_rdata, 32'h33);
        $display("txn read 0x30 rdata=0x%08h after 3 waits", rsp_rdata);
        step();
        chk("t3_rsp1_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t3_rsp1_rdata", rsp_rdata, 32'h44);
        $display("txn read 0x34 rdata=0x%08h", rsp_rdata);
        step();

        // 4: ERROR on write 0x20 with read 0x24 queued
        issue(32'h20, 1'b1, 3'd2, 32'h12345678);
        step();
        issue(32'h24, 1'b0, 3'd2, 32'h0);
        step(); req_vld = 1'b0;
        HREADY = 1'b0; HRESP = 1'b1;
        #1 chk("t4_err1_htrans", {30'h0, HTRANS}, 32'h2);
        step();
        chk("t4_err2_htrans", {30'h0, HTRANS}, 32'h0);
        chk("t4_err2_req_rdy", {31'h0, req_rdy}, 32'h0);
        chk("t4_err2_hwdata", HWDATA, 32'h12345678);
        HREADY = 1'b1;
        step();
        HRESP = 1'b0; HRDATA = 32'h55;
        chk("t4_rsp_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t4_rsp_err", {31'h0, rsp_err}, 32'h1);
        chk("t4_reissue_htrans", {30'h0, HTRANS}, 32'h2);
        chk("t4_reissue_haddr", HADDR, 32'h24);
        chk("t4_reissue_hwrite", {31'h0, HWRITE}, 32'h0);
        $display("txn write 0x20 rsp_err=%0d", rsp_err);
        step();
        chk("t4_gap", {31'h0, rsp_vld}, 32'h0);
        step();
        chk("t4_rd_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t4_rd_err", {31'h0, rsp_err}, 32'h0);
        chk("t4_rd_rdata", rsp_rdata, 32'h55);
        $display("txn read 0x24 rdata=0x%08h rsp_err=%0d", rsp_rdata, rsp_err);
        step();

        // 5: byte write and constant attributes
        issue(32'h3, 1'b1, 3'd0, 32'hAB);
        step(); req_vld = 1'b0;
        chk("t5_hsize", {29'h0, HSIZE}, 32'h0);
        chk("t5_haddr", HADDR, 32'h3);
        chk("t5_hburst", {29'h0, HBURST}, 32'h0);
        chk("t5_hmastlock", {31'h0, HMASTLOCK}, 32'h0);
        chk("t5_hprot", {28'h0, HPROT}, 32'h3);
        step(); step();
        chk("t5_rsp_vld", {31'h0, rsp_vld}, 32'h1);
        $display("txn byte write 0x3 rsp_vld=%0d", rsp_vld);
        step();

        // 6: reset during a data phase
        issue(32'h40, 1'b0, 3'd2, 32'h0);
        step(); req_vld = 1'b0;
        step();
        HREADY = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_htrans_rst", {30'h0, HTRANS}, 32'h0);
        chk("t6_req_rdy_rst", {31'h0, req_rdy}, 32'h0);
        chk("t6_rsp_rst", {31'h0, rsp_vld}, 32'h0);
        HREADY = 1'b1;
        step();
        chk("t6_no_rsp", {31'h0, rsp_vld}, 32'h0);
        HRESETn = 1'b1;
        #1;
        chk("t6_req_rdy_after", {31'h0, req_rdy}, 32'h1);
        chk("t6_htrans_after", {30'h0, HTRANS}, 32'h0);
        issue(32'h50, 1'b1, 3'd2, 32'h77);
        step(); req_vld = 1'b0;
        chk("t6_haddr", HADDR, 32'h50);
        chk("t6_htrans", {30'h0, HTRANS}, 32'h2);
        step();
        chk("t6_hwdata", HWDATA, 32'h77);
        step();
        chk("t6_rsp_vld", {31'h0, rsp_vld}, 32'h1);
        chk("t6_rsp_err", {31'h0, rsp_err}, 32'h0);
        $display("txn write 0x50 after reset rsp_vld=%0d", rsp_vld);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
